// File: rtl/io_inport_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : io_inport_loader_if
// Description : Board-side bundle between raw switches/buttons and the
//               conditioned INPORT0/INPORT1/run outputs of io_inport_loader.
//               The master modport drives the raw inputs. The slave modport
//               is the loader itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_inport_loader_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       buttons;     // raw, active-low: [1] load, [0] run
  logic [9:0]       switches;    // raw: [9] port select, [8:0] data
  logic [WIDTH-1:0] inport0;
  logic [WIDTH-1:0] inport1;
  logic             inport0_wr;
  logic             inport1_wr;
  logic             run_pulse;

  modport master (
    output buttons, switches,
    input  inport0, inport1, inport0_wr, inport1_wr, run_pulse
  );

  modport slave (
    input  buttons, switches,
    output inport0, inport1, inport0_wr, inport1_wr, run_pulse
  );
endinterface
`default_nettype wire

// File: rtl/io_inport_loader.sv
`default_nettype none
// ============================================================================
// Module      : io_inport_loader
// Description : Synchronizes raw switches and active-low buttons, debounces
//               each button with a RELEASED/PRESSED FSM, and turns accepted
//               presses into INPORT loads (buttons[1]) and run pulses
//               (buttons[0]).
// Revision    : 1.0 - initial release
// ============================================================================
module io_inport_loader #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  io_inport_loader_if.slave  bus
);

  // Counter only has to hold DEBOUNCE_CYCLES-1: the cycle that would reach
  // DEBOUNCE_CYCLES is the accept cycle and clears it instead.
  localparam int c_cnt_w = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] c_st_released = 1'b0;
  localparam logic [0:0] c_st_pressed  = 1'b1;

  logic [9:0]       r_sw_sync [SYNC_STAGES];
  logic [9:0]       w_sw;
  logic [1:0]       w_press;
  logic [WIDTH-1:0] r_inport0;
  logic [WIDTH-1:0] r_inport1;
  logic             r_inport0_wr;
  logic             r_inport1_wr;
  logic             r_run_pulse;

  // Switch synchronizer chain; switches are level inputs and are not debounced.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sw_sync[i] <= '0;
    end else begin
      r_sw_sync[0] <= bus.switches;
      for (int i = 1; i < SYNC_STAGES; i++) r_sw_sync[i] <= r_sw_sync[i-1];
    end
  end

  assign w_sw = r_sw_sync[SYNC_STAGES-1];

  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : g_btn
      logic [SYNC_STAGES-1:0] r_sync;
      logic [c_cnt_w-1:0]     r_cnt;
      logic [0:0]             r_state;
      logic                   w_level;
      logic                   w_accepted_level;
      logic                   w_differs;
      logic                   w_accept;

      // Button synchronizer; resets to released (1) so a button held through
      // reset release is treated as a fresh press.
      always_ff @(posedge clk) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.buttons[b]};
      end

      assign w_level          = r_sync[SYNC_STAGES-1];
      assign w_accepted_level = (r_state == c_st_released);
      assign w_differs        = (w_level != w_accepted_level);
      // The cycle whose edge brings the count to DEBOUNCE_CYCLES accepts.
      assign w_accept         = w_differs && (r_cnt == c_cnt_last);

      // Debounce counter and RELEASED/PRESSED state update.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt   <= '0;
          r_state <= c_st_released;
        end else if (!w_differs) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_cnt   <= '0;
          r_state <= w_level ? c_st_released : c_st_pressed;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      // Press event: accepted low level while RELEASED; releases give none.
      assign w_press[b] = w_accept && (r_state == c_st_released);
    end
  endgenerate

  // Load selected inport on a load press, and emit the run pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inport0    <= '0;
      r_inport1    <= '0;
      r_inport0_wr <= 1'b0;
      r_inport1_wr <= 1'b0;
      r_run_pulse  <= 1'b0;
    end else begin
      r_inport0_wr <= 1'b0;
      r_inport1_wr <= 1'b0;
      r_run_pulse  <= w_press[0];
      if (w_press[1]) begin
        if (w_sw[9]) begin
          r_inport1    <= {{(WIDTH-9){1'b0}}, w_sw[8:0]};
          r_inport1_wr <= 1'b1;
        end else begin
          r_inport0    <= {{(WIDTH-9){1'b0}}, w_sw[8:0]};
          r_inport0_wr <= 1'b1;
        end
      end
    end
  end

  assign bus.inport0    = r_inport0;
  assign bus.inport1    = r_inport1;
  assign bus.inport0_wr = r_inport0_wr;
  assign bus.inport1_wr = r_inport1_wr;
  assign bus.run_pulse  = r_run_pulse;

endmodule
`default_nettype wire

// File: tb/tb_io_inport_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_inport_loader
// Description : Self-checking bench for io_inport_loader: directed scenarios
//               plus randomized button/switch activity compared every cycle
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_inport_loader;

  localparam int c_width = 32;
  localparam int c_sync  = 2;
  localparam int c_deb   = 4;

  logic clk;
  logic rst;

  io_inport_loader_if #(.WIDTH(c_width)) bus ();

  io_inport_loader #(
    .WIDTH(c_width), .SYNC_STAGES(c_sync), .DEBOUNCE_CYCLES(c_deb)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;
  int cyc;
  bit model_ok;

  // Strobe statistics collected at each sample point.
  int cnt_wr0, cnt_wr1, cnt_run;
  int last_wr0, last_wr1, last_run;

  // Reference model: raw inputs reach the debouncer c_sync edges after being
  // sampled; a level is accepted after c_deb consecutive differing cycles.
  logic [1:0]          bq[$];
  logic [9:0]          sq[$];
  int                  run_len [2];
  bit                  acc [2];
  logic [c_width-1:0]  e_in0, e_in1;
  logic                e_wr0, e_wr1, e_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model update on every active edge.
  always @(posedge clk) begin
    if (rst) begin
      bq = {};
      sq = {};
      for (int i = 0; i < c_sync; i++) begin
        bq.push_back(2'b11);
        sq.push_back(10'h000);
      end
      for (int i = 0; i < 2; i++) begin
        run_len[i] = 0;
        acc[i]     = 1'b1;
      end
      e_in0 = '0; e_in1 = '0;
      e_wr0 = 1'b0; e_wr1 = 1'b0; e_run = 1'b0;
    end else begin
      logic [1:0] bu;
      logic [9:0] su;
      logic [1:0] ev;
      bu = bq.pop_front();
      su = sq.pop_front();
      bq.push_back(bus.buttons);
      sq.push_back(bus.switches);
      ev = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (bu[i] != acc[i]) begin
          run_len[i]++;
          if (run_len[i] == c_deb) begin
            acc[i]     = bu[i];
            run_len[i] = 0;
            ev[i]      = (bu[i] == 1'b0);
          end
        end else begin
          run_len[i] = 0;
        end
      end
      e_wr0 = 1'b0; e_wr1 = 1'b0;
      e_run = ev[0];
      if (ev[1]) begin
        if (su[9]) begin e_in1 = c_width'(su[8:0]); e_wr1 = 1'b1; end
        else       begin e_in0 = c_width'(su[8:0]); e_wr0 = 1'b1; end
      end
    end
  end

  // One cycle: sample at the falling edge, compare with the model, log strobes.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (model_ok) begin
      chk("inport0",    bus.inport0,    e_in0);
      chk("inport1",    bus.inport1,    e_in1);
      chk("inport0_wr", {31'b0, bus.inport0_wr}, {31'b0, e_wr0});
      chk("inport1_wr", {31'b0, bus.inport1_wr}, {31'b0, e_wr1});
      chk("run_pulse",  {31'b0, bus.run_pulse},  {31'b0, e_run});
    end
    if (bus.inport0_wr === 1'b1) begin cnt_wr0++; last_wr0 = cyc; end
    if (bus.inport1_wr === 1'b1) begin cnt_wr1++; last_wr1 = cyc; end
    if (bus.run_pulse  === 1'b1) begin cnt_run++; last_run = cyc; end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clr_stats();
    cnt_wr0 = 0; cnt_wr1 = 0; cnt_run = 0;
    last_wr0 = -1; last_wr1 = -1; last_run = -1;
  endtask

  int start;

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0; model_ok = 1'b0;
    clr_stats();
    rst = 1'b1;
    bus.buttons  = 2'b11;
    bus.switches = 10'h3FF;

    // Reset for two cycles, then quiet for 20 cycles.
    cycles(2);
    model_ok = 1'b1;
    chk("rst_inport0", bus.inport0, 32'h0);
    chk("rst_inport1", bus.inport1, 32'h0);
    chk("rst_strobes", {29'b0, bus.inport0_wr, bus.inport1_wr, bus.run_pulse}, 32'h0);
    rst = 1'b0;
    clr_stats();
    cycles(20);
    chk("idle_strobes", cnt_wr0 + cnt_wr1 + cnt_run, 0);

    // Load inport0 with 0x0A5; strobe in the cycle after edge E+5.
    bus.switches = 10'h0A5;
    bus.buttons  = 2'b01;
    clr_stats();
    start = cyc;
    cycles(10);
    bus.buttons = 2'b11;
    cycles(10);
    chk("ld0_count",   cnt_wr0, 1);
    chk("ld0_latency", last_wr0 - start, 6);
    chk("ld0_value",   bus.inport0, 32'h000000A5);
    chk("ld0_other",   bus.inport1, 32'h0);
    chk("ld0_wr1",     cnt_wr1, 0);

    // Load inport1 with 0x0FF, held 50 cycles -> single strobe.
    bus.switches = 10'h2FF;
    bus.buttons  = 2'b01;
    clr_stats();
    cycles(50);
    bus.buttons = 2'b11;
    cycles(10);
    chk("ld1_count", cnt_wr1, 1);
    chk("ld1_value", bus.inport1, 32'h000000FF);
    chk("ld1_keep0", bus.inport0, 32'h000000A5);

    // Bounce: 3 low / 1 high, five times -> no loads.
    bus.switches = 10'h155;
    clr_stats();
    for (int k = 0; k < 5; k++) begin
      bus.buttons = 2'b01; cycles(3);
      bus.buttons = 2'b11; cycles(1);
    end
    cycles(10);
    chk("bounce_wr", cnt_wr0 + cnt_wr1, 0);
    chk("bounce_in0", bus.inport0, 32'h000000A5);
    chk("bounce_in1", bus.inport1, 32'h000000FF);

    // Both buttons from the same edge -> run and load in the same cycle.
    bus.switches = 10'h001;
    bus.buttons  = 2'b00;
    clr_stats();
    cycles(10);
    bus.buttons = 2'b11;
    cycles(10);
    chk("sim_run_count", cnt_run, 1);
    chk("sim_wr0_count", cnt_wr0, 1);
    chk("sim_same_cycle", last_run, last_wr0);
    chk("sim_value", bus.inport0, 32'h00000001);

    // Reset in the middle of a debounce of buttons[0].
    bus.buttons = 2'b10;
    clr_stats();
    cycles(3);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    start = cyc;
    chk("mid_rst_early", cnt_run, 0);
    cycles(12);
    chk("mid_rst_count",   cnt_run, 1);
    chk("mid_rst_latency", last_run - start, 6);
    chk("mid_rst_in0",     bus.inport0, 32'h0);
    bus.buttons = 2'b11;
    cycles(10);

    // Randomized activity: random hold lengths straddle the debounce window.
    for (int k = 0; k < 120; k++) begin
      bus.buttons  = 2'($urandom_range(0, 3));
      bus.switches = 10'($urandom);
      if ($urandom_range(0, 59) == 0) rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycles($urandom_range(0, 9));
    end
    bus.buttons = 2'b11;
    cycles(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
